// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    Idle,
    Request,
    Discard,
    Misaligned
  } fetch_state_t;

  localparam logic [31:0] NopInstruction = 32'h0000_0013;

  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_pkg.sv
// Instruction-encoding types shared by fetch and decode.
package instruction_pkg;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OpLoad   = 7'h03;
  localparam opcode_t OpImm    = 7'h13;
  localparam opcode_t OpAuipc  = 7'h17;
  localparam opcode_t OpStore  = 7'h23;
  localparam opcode_t OpReg    = 7'h33;
  localparam opcode_t OpLui    = 7'h37;
  localparam opcode_t OpBranch = 7'h63;
  localparam opcode_t OpJalr   = 7'h67;
  localparam opcode_t OpJal    = 7'h6f;
  localparam opcode_t OpSystem = 7'h73;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, word} entries.
// Ports: clock/reset (sync, active-low), push_i/push_data_i, pop_i,
// flush_i (clears all entries, wins over push/pop), head_data_o, full_o, empty_o.
module fetch_buffer #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = count_q == (PtrW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads 32-bit words over a Wishbone-classic read
// port, buffers them with their PC and presents them to decode under a
// valid/ready handshake. Redirects flush the buffer and restart fetch.
// Ports: clock, reset (sync, active-low); redirect_en/redirect_pc;
// Wishbone mem_cyc/mem_stb/mem_addr/mem_ack/mem_rd_dat; decode side
// inst_valid/inst_ready/inst/inst_pc/inst_opcode/inst_funct3/inst_funct7/
// inst_misaligned.
//
// state      | meaning
// Idle       | no bus cycle; start one when the buffer has a free slot
// Request    | bus read at fetch_pc outstanding; ack pushes the word
// Discard    | redirected while a read was outstanding; drop its ack
// Misaligned | redirect target not word aligned; report it at the head
module instruction_fetch_unit
  import fetch_unit_pkg::*;
  import instruction_pkg::*;
#(
  parameter int                  DATA_SIZE    = 64,
  parameter logic [DATA_SIZE-1:0] RESET_PC    = '0,
  parameter int                  BUFFER_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 redirect_en,
  input  logic [DATA_SIZE-1:0] redirect_pc,
  output logic                 mem_cyc,
  output logic                 mem_stb,
  output logic [DATA_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rd_dat,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [31:0]          inst,
  output logic [DATA_SIZE-1:0] inst_pc,
  output opcode_t              inst_opcode,
  output logic [2:0]           inst_funct3,
  output logic [6:0]           inst_funct7,
  output logic                 inst_misaligned
);

  fetch_state_t           state_q, state_d;
  logic [DATA_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
  logic                   push;
  logic                   buf_full, buf_empty;
  logic [DATA_SIZE+31:0]  head_data;

  fetch_buffer #(
    .WIDTH(DATA_SIZE + 32),
    .DEPTH(BUFFER_DEPTH)
  ) u_fetch_buffer (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({fetch_pc_q, mem_rd_dat}),
    .pop_i       (inst_valid && inst_ready),
    .flush_i     (redirect_en),
    .head_data_o (head_data),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    unique case (state_q)
      Idle:       if (!buf_full) state_d = Request;
      Request: begin
        if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + DATA_SIZE'(4);
          state_d    = Idle;
        end
      end
      // fetch_pc already holds the redirect target, so its low bits
      // decide where to go once the stale cycle completes.
      Discard:    if (mem_ack) state_d = addr_misaligned(fetch_pc_q[1:0]) ? Misaligned : Idle;
      Misaligned: state_d = Misaligned;
      default:    state_d = Idle;
    endcase
    if (redirect_en) begin
      push       = 1'b0;
      fetch_pc_d = redirect_pc;
      if ((state_q == Request || state_q == Discard) && !mem_ack) state_d = Discard;
      else state_d = addr_misaligned(redirect_pc[1:0]) ? Misaligned : Idle;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= Idle;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign mem_cyc  = (state_q == Request) || (state_q == Discard);
  assign mem_stb  = mem_cyc;
  assign mem_addr = fetch_pc_q;

  always_comb begin
    inst_valid      = 1'b0;
    inst            = '0;
    inst_pc         = '0;
    inst_misaligned = 1'b0;
    if (state_q == Misaligned) begin
      inst_valid      = 1'b1;
      inst_pc         = fetch_pc_q;
      inst_misaligned = 1'b1;
    end else if (!buf_empty) begin
      inst_valid = 1'b1;
      inst       = head_data[31:0];
      inst_pc    = head_data[DATA_SIZE+31:32];
    end
  end

  assign inst_opcode = inst[6:0];
  assign inst_funct3 = inst[14:12];
  assign inst_funct7 = inst[31:25];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  localparam int DS = 64;
  localparam int DEPTH = 2;
  localparam logic [DS-1:0] RST_PC = '0;

  logic          clock = 1'b0;
  logic          reset, redirect_en, mem_ack, inst_ready;
  logic [DS-1:0] redirect_pc;
  logic [31:0]   mem_rd_dat;
  logic          mem_cyc, mem_stb, inst_valid, inst_misaligned;
  logic [DS-1:0] mem_addr, inst_pc;
  logic [31:0]   inst;
  logic [6:0]    inst_opcode, inst_funct7;
  logic [2:0]    inst_funct3;

  always #5 clock = ~clock;

  instruction_fetch_unit #(.DATA_SIZE(DS), .RESET_PC(RST_PC), .BUFFER_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rd_dat(mem_rd_dat), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_opcode(inst_opcode), .inst_funct3(inst_funct3),
    .inst_funct7(inst_funct7), .inst_misaligned(inst_misaligned));

  int checks = 0, errors = 0;
  // reference model: next instruction decode must see, plus memory responder state
  logic [DS-1:0] exp_pc = '0;
  int pops = 0, ack_count = 0, ack_lat = 1, cur_lat = 1, wait_cnt = 0;
  bit ack_rand = 0, req_active = 0, redir_seen = 0, new_req = 0, mon_en = 0;
  logic [DS-1:0] req_addr = '0;
  logic found;

  function automatic logic [31:0] mem_word(input logic [DS-1:0] a);
    if (a == '0) return 32'h0050_0093;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check the head against the model, advance the model on
  // the edge, then compute the memory response for the new cycle.
  task automatic tick();
    logic popped;
    new_req = 0;
    if (mon_en) begin
      check("cyc_eq_stb", {63'd0, mem_cyc}, {63'd0, mem_stb});
      if (!inst_valid) begin
        check("idle_pc_zero", inst_pc, 64'd0);
        check("idle_fields_zero", {14'd0, inst_misaligned, inst_funct7, inst_funct3, inst_opcode, inst}, 64'd0);
      end else begin
        check("head_pc", inst_pc, exp_pc);
        check("head_misaligned", {63'd0, inst_misaligned}, {63'd0, exp_pc[1:0] != 2'b00});
        check("head_inst", {32'd0, inst}, (exp_pc[1:0] != 2'b00) ? 64'd0 : {32'd0, mem_word(exp_pc)});
        check("head_fields", {47'd0, inst_funct7, inst_funct3, inst_opcode},
              {47'd0, inst[31:25], inst[14:12], inst[6:0]});
      end
    end
    popped = inst_valid && inst_ready;
    if (!reset) exp_pc = RST_PC;
    else if (redirect_en) exp_pc = redirect_pc;
    else if (popped && exp_pc[1:0] == 2'b00) begin
      exp_pc = exp_pc + 64'd4;
      pops++;
    end
    if (!reset || mem_ack) req_active = 0;
    else if (redirect_en && req_active) redir_seen = 1;
    @(posedge clock);
    #1;
    mon_en = 1;
    if (mem_stb) begin
      if (!req_active) begin
        req_active = 1; wait_cnt = 0; req_addr = mem_addr; redir_seen = 0; new_req = 1;
        cur_lat = ack_rand ? int'($urandom_range(0, 3)) : ack_lat;
      end else begin
        wait_cnt++;
        if (!redir_seen) check("addr_stable", mem_addr, req_addr);
      end
      mem_ack = (cur_lat >= 0) && (wait_cnt >= cur_lat);
      mem_rd_dat = mem_ack ? mem_word(req_addr) : $urandom;
      if (mem_ack) ack_count++;
    end else begin
      req_active = 0;
      mem_ack = 0;
      mem_rd_dat = $urandom;
    end
  endtask

  task automatic do_reset();
    reset = 0; redirect_en = 0; ack_rand = 0;
    repeat (3) tick();
    check("rst_cyc", {63'd0, mem_cyc}, 64'd0);
    check("rst_valid", {63'd0, inst_valid}, 64'd0);
    ack_count = 0;
    reset = 1;
  endtask

  task automatic wait_req(input int max);
    found = 0;
    for (int i = 0; i < max && !found; i++) begin
      tick();
      found = new_req;
    end
    check("req_timeout", {63'd0, found}, 64'd1);
  endtask

  task automatic wait_valid(input int max);
    found = 0;
    for (int i = 0; i < max && !found; i++) begin
      tick();
      found = inst_valid;
    end
    check("valid_timeout", {63'd0, found}, 64'd1);
  endtask

  initial begin
    reset = 0; redirect_en = 0; redirect_pc = '0; mem_ack = 0; mem_rd_dat = '0; inst_ready = 1;

    // 1: reset latency and first fetches
    ack_lat = 1;
    do_reset();
    check("t1_c0_stb", {63'd0, mem_stb}, 64'd0);
    tick();
    check("t1_c1_stb", {63'd0, mem_stb}, 64'd1);
    check("t1_c1_addr", mem_addr, 64'd0);
    tick();
    check("t1_c2_valid", {63'd0, inst_valid}, 64'd0);
    tick();
    check("t1_c3_valid", {63'd0, inst_valid}, 64'd1);
    check("t1_inst", {32'd0, inst}, 64'h0050_0093);
    check("t1_opcode", {57'd0, inst_opcode}, 64'h13);
    check("t1_f3f7", {54'd0, inst_funct3, inst_funct7}, 64'd0);
    wait_req(10);
    check("t1_addr4", mem_addr, 64'd4);
    wait_req(10);
    check("t1_addr8", mem_addr, 64'd8);

    // 2: full buffer stalls the bus
    inst_ready = 0; ack_lat = 0;
    do_reset();
    repeat (12) tick();
    check("t2_reads", ack_count, DEPTH);
    check("t2_stb_low", {63'd0, mem_stb}, 64'd0);
    inst_ready = 1;
    wait_req(10);
    check("t2_resume_addr", mem_addr, 64'd8);
    repeat (10) tick();

    // 3: redirect while a read waits for ack
    ack_lat = 3;
    do_reset();
    tick();
    check("t3_stb", {63'd0, mem_stb}, 64'd1);
    redirect_en = 1; redirect_pc = 64'h100;
    tick();
    redirect_en = 0;
    check("t3_discard_cyc", {63'd0, mem_cyc}, 64'd1);
    wait_req(20);
    check("t3_new_addr", mem_addr, 64'h100);
    wait_valid(20);
    check("t3_first_pc", inst_pc, 64'h100);

    // 4: redirect coinciding with ack and pop
    inst_ready = 0; ack_lat = 0;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = mem_stb && mem_ack && inst_valid;
    end
    check("t4_setup", {63'd0, found}, 64'd1);
    inst_ready = 1; redirect_en = 1; redirect_pc = 64'h40;
    tick();
    redirect_en = 0;
    check("t4_empty", {63'd0, inst_valid}, 64'd0);
    wait_req(10);
    check("t4_addr", mem_addr, 64'h40);
    wait_valid(10);
    check("t4_pc", inst_pc, 64'h40);

    // 5: misaligned redirect target
    inst_ready = 0; ack_lat = 1;
    do_reset();
    redirect_en = 1; redirect_pc = 64'h102;
    tick();
    redirect_en = 0; inst_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("t5_no_bus", {63'd0, mem_cyc}, 64'd0);
      check("t5_valid", {63'd0, inst_valid}, 64'd1);
      check("t5_mis", {63'd0, inst_misaligned}, 64'd1);
      check("t5_pc", inst_pc, 64'h102);
      tick();
    end
    redirect_en = 1; redirect_pc = 64'h200;
    tick();
    redirect_en = 0;
    wait_req(10);
    check("t5_addr", mem_addr, 64'h200);
    wait_valid(10);
    check("t5_pc200", inst_pc, 64'h200);

    // 6: address wrap, then reset mid-request
    ack_lat = 1;
    do_reset();
    redirect_en = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_en = 0;
    wait_req(10);
    check("t6_top_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    ack_lat = -1;
    wait_req(10);
    check("t6_wrap_addr", mem_addr, 64'd0);
    tick();
    check("t6_req_held", {63'd0, mem_cyc}, 64'd1);
    reset = 0;
    tick();
    check("t6_rst_cyc", {63'd0, mem_cyc}, 64'd0);
    check("t6_rst_valid", {63'd0, inst_valid}, 64'd0);

    // random traffic against the stream model
    ack_lat = 1;
    do_reset();
    ack_rand = 1; pops = 0;
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_en = ($urandom_range(0, 39) == 0);
      if (redirect_en)
        redirect_pc = {52'd0, 10'($urandom_range(0, 1023)), 2'b00} |
                      (($urandom_range(0, 7) == 0) ? 64'd2 : 64'd0);
      tick();
    end
    redirect_en = 0;
    check("rand_progress", {63'd0, pops > 200}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
